acc_op_sequencer: RTL and testbench

//  Multi-cycle sequencer for the accumulator datapath.
//  - Accepts one ACC operation at a time from the control unit over a valid/ready handshake.
//  - Drives the ACC control lines: C7 (ACC->ALU P), C9 (BR->ACC), C10 (MR->ACC), C11 (MBR->ACC), C12 (ACC->MBR).
//  - Drives the ALU start/op lines and waits for multi-cycle ALU results.
//  - Arbitrates the user-sample port (ACC readout) against CU operations.

---
 rtl/acc_seq_pkg.sv | 36 +++
 rtl/acc_wait_timer.sv | 31 +++
 rtl/acc_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_acc_op_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// Purpose: shared opcode encodings, FSM state type and opcode class helpers for the ACC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_seq_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_MPY   = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT_ALU,
    ST_WB,
    ST_USER
  } state_t;

  // Single-cycle ALU ops: ADD..SHR form a contiguous code range.
  function automatic logic OP_IS_ALU1(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // Multi-cycle ALU ops that must wait for i_alu_done.
  function automatic logic OP_IS_MULTI(input logic [3:0] op);
    return (op == OP_MPY) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/acc_wait_timer.sv
// Purpose: loadable down-counter with saturation at zero; flags when it has run out.
// Latency: load/decrement take effect on the next rising edge; o_zero is combinational from the count.
// Backpressure: none; load has priority over decrement.
module acc_wait_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  // Count register: reload wins, otherwise count down and stick at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= RST_VAL;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/acc_op_sequencer.sv
// Purpose: sequences one CU accumulator op at a time onto the ACC control lines and ALU, and arbitrates user ACC samples.
// Latency: LOAD/STORE/illegal done 1 cycle after accept, single-cycle ALU 2, MPY/DIV 2 + WAIT_ALU cycles; user ack 1 cycle after grant.
// Backpressure: o_op_ready low while busy or while a user request wins IDLE arbitration.
module acc_op_sequencer
  import acc_seq_pkg::*;
#(
  parameter int MAX_ALU_CYCLES = 32,
  parameter int USER_MAX_WAIT  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_op_valid,
  input  logic [3:0] i_opcode,
  output logic       o_op_ready,
  output logic       o_op_done,
  output logic       o_err,
  output logic       o_alu_start,
  output logic [3:0] o_alu_op,
  input  logic       i_alu_done,
  output logic       C7,
  output logic       C9,
  output logic       C10,
  output logic       C11,
  output logic       C12,
  input  logic       i_user_req,
  output logic       o_user_sample,
  output logic       o_user_ack,
  output logic       o_busy
);

  // Both timers count down: the ALU timer starts at MAX_ALU_CYCLES-1 and
  // expires in the last allowed WAIT_ALU cycle; the starvation timer starts
  // at USER_MAX_WAIT (i.e. zero losses so far) and reads zero once starved.
  localparam logic [7:0] ALU_TMO_INIT   = 8'(MAX_ALU_CYCLES - 1);
  localparam logic [7:0] USER_WAIT_INIT = 8'(USER_MAX_WAIT);

  state_t     state_q, state_d;
  logic [3:0] op_q;
  logic       starved, user_win, accept, user_grant, user_lose, tmo_zero;

  // The user only loses arbitration in IDLE while an op is taken instead;
  // busy cycles hold the count so the user waits for USER_MAX_WAIT ops.
  assign user_win   = i_user_req && (!i_op_valid || starved);
  assign o_op_ready = i_rst_n && (state_q == ST_IDLE) && !user_win;
  assign accept     = i_op_valid && o_op_ready;
  assign user_grant = (state_q == ST_IDLE) && user_win;
  assign user_lose  = (state_q == ST_IDLE) && i_user_req && !user_win;
  assign o_alu_op   = op_q;
  assign o_busy     = (state_q != ST_IDLE);

  acc_wait_timer #(.W(8), .RST_VAL(8'd0)) u_alu_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (state_q == ST_EXEC),
    .i_load_val (ALU_TMO_INIT),
    .i_dec      (state_q == ST_WAIT_ALU),
    .o_zero     (tmo_zero)
  );

  acc_wait_timer #(.W(8), .RST_VAL(USER_WAIT_INIT)) u_starve_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (!i_user_req || user_grant),
    .i_load_val (USER_WAIT_INIT),
    .i_dec      (user_lose),
    .o_zero     (starved)
  );

  // State and latched opcode; opcode captured on the accepting edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= i_opcode;
      end
    end
  end

  // Next state and control lines decoded from the registered state and opcode.
  always_comb begin
    state_d       = state_q;
    o_op_done     = 1'b0;
    o_err         = 1'b0;
    o_alu_start   = 1'b0;
    C7            = 1'b0;
    C9            = 1'b0;
    C10           = 1'b0;
    C11           = 1'b0;
    C12           = 1'b0;
    o_user_sample = 1'b0;
    o_user_ack    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (user_win) begin
          state_d = ST_USER;
        end else if (accept) begin
          state_d = ST_EXEC;
        end
      end
      ST_USER: begin
        o_user_sample = 1'b1;
        o_user_ack    = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_EXEC: begin
        if (op_q == OP_LOAD) begin
          C11       = 1'b1;
          o_op_done = 1'b1;
          state_d   = ST_IDLE;
        end else if (op_q == OP_STORE) begin
          C12       = 1'b1;
          o_op_done = 1'b1;
          state_d   = ST_IDLE;
        end else if (OP_IS_ALU1(op_q)) begin
          C7          = 1'b1;
          o_alu_start = 1'b1;
          state_d     = ST_WB;
        end else if (OP_IS_MULTI(op_q)) begin
          C7          = 1'b1;
          o_alu_start = 1'b1;
          state_d     = ST_WAIT_ALU;
        end else begin
          o_op_done = 1'b1;
          o_err     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_ALU: begin
        C7 = 1'b1;
        // A result arriving in the final allowed cycle still counts.
        if (i_alu_done) begin
          state_d = ST_WB;
        end else if (tmo_zero) begin
          o_op_done = 1'b1;
          o_err     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WB: begin
        o_op_done = 1'b1;
        if (op_q == OP_MPY) begin
          C10 = 1'b1;
        end else begin
          C9 = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Purpose: directed self-checking bench for acc_op_sequencer.
// Latency: inputs driven just after the falling edge, outputs sampled 1-2 time units later.
// Backpressure: op issue checks o_op_ready before relying on acceptance.
module tb_acc_op_sequencer;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       op_valid = 1'b0;
  logic [3:0] opcode   = 4'h0;
  logic       alu_done = 1'b0;
  logic       user_req = 1'b0;

  logic       o_op_ready, o_op_done, o_err, o_alu_start;
  logic [3:0] o_alu_op;
  logic       C7, C9, C10, C11, C12;
  logic       o_user_sample, o_user_ack, o_busy;

  logic [4:0]  cl;
  logic [16:0] outs;

  int n_assert = 0;
  int n_fail   = 0;

  assign cl   = {C7, C9, C10, C11, C12};
  assign outs = {o_op_ready, o_op_done, o_err, o_alu_start, o_alu_op, cl,
                 o_user_sample, o_user_ack, o_busy};

  acc_op_sequencer #(.MAX_ALU_CYCLES(32), .USER_MAX_WAIT(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_op_valid    (op_valid),
    .i_opcode      (opcode),
    .o_op_ready    (o_op_ready),
    .o_op_done     (o_op_done),
    .o_err         (o_err),
    .o_alu_start   (o_alu_start),
    .o_alu_op      (o_alu_op),
    .i_alu_done    (alu_done),
    .C7            (C7),
    .C9            (C9),
    .C10           (C10),
    .C11           (C11),
    .C12           (C12),
    .i_user_req    (user_req),
    .o_user_sample (o_user_sample),
    .o_user_ack    (o_user_ack),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Present an op in IDLE; returns in the first cycle after acceptance (T1).
  task automatic issue(input logic [3:0] op);
    opcode   = op;
    op_valid = 1'b1;
    #1;
    chk("issue_ready", o_op_ready, 1);
    cyc();
    op_valid = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state, including the gated ready.
    repeat (2) cyc();
    chk("reset_outs", outs, 0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", o_op_ready, 1);
    chk("reset_busy", o_busy, 0);

    // LOAD: done at T1 with only C11.
    issue(4'h1);
    chk("load_cl", cl, 5'b00010);
    chk("load_done_err", {o_op_done, o_err}, 2'b10);
    chk("load_ready_busy", {o_op_ready, o_busy}, 2'b01);
    cyc();
    chk("load_idle", {o_busy, o_op_done}, 2'b00);

    // STORE: done at T1 with only C12.
    issue(4'h2);
    chk("store_cl", cl, 5'b00001);
    chk("store_done_err", {o_op_done, o_err}, 2'b10);
    cyc();

    // ADD: start at T1, C9 write-back at T2.
    issue(4'h3);
    chk("add_t1_cl", cl, 5'b10000);
    chk("add_t1_start", o_alu_start, 1);
    chk("add_t1_op", o_alu_op, 4'h3);
    chk("add_t1_done", o_op_done, 0);
    cyc();
    chk("add_t2_cl", cl, 5'b01000);
    chk("add_t2_done_err_start", {o_op_done, o_err, o_alu_start}, 3'b100);
    cyc();
    chk("add_idle", o_busy, 0);

    // MPY: alu_done in 5th WAIT_ALU cycle (T6), C10 write-back at T7.
    issue(4'hA);
    chk("mpy_t1", {cl, o_alu_start}, 6'b100001);
    chk("mpy_t1_op", o_alu_op, 4'hA);
    repeat (4) begin
      cyc();
      chk("mpy_wait", {cl, o_op_done, o_alu_start}, 7'b1000000);
    end
    cyc();
    alu_done = 1'b1;
    #1;
    chk("mpy_t6_done", o_op_done, 0);
    cyc();
    alu_done = 1'b0;
    chk("mpy_t7_cl", cl, 5'b00100);
    chk("mpy_t7_done_err", {o_op_done, o_err}, 2'b10);
    cyc();
    chk("mpy_idle", o_busy, 0);

    // DIV timeout: error on the 32nd WAIT_ALU cycle, no write-back.
    issue(4'hB);
    chk("div_t1_start", o_alu_start, 1);
    repeat (31) begin
      cyc();
      chk("div_wait", {o_op_done, o_err, C7}, 3'b001);
    end
    cyc();
    chk("div_tmo_done_err", {o_op_done, o_err}, 2'b11);
    chk("div_tmo_no_wb", {C9, C10}, 2'b00);
    cyc();
    chk("div_tmo_idle", {o_busy, o_op_done}, 2'b00);

    // DIV with result in the timeout cycle: result wins, C9 write-back.
    issue(4'hB);
    repeat (31) cyc();
    cyc();
    alu_done = 1'b1;
    #1;
    chk("div_race_no_err", {o_op_done, o_err}, 2'b00);
    cyc();
    alu_done = 1'b0;
    chk("div_race_cl", cl, 5'b01000);
    chk("div_race_done_err", {o_op_done, o_err}, 2'b10);
    cyc();

    // Illegal opcodes: error at T1, no control lines.
    issue(4'hC);
    chk("illegal_c", {o_op_done, o_err, cl, o_alu_start}, 8'b11000000);
    cyc();
    issue(4'h0);
    chk("illegal_0", {o_op_done, o_err, cl, o_alu_start}, 8'b11000000);
    cyc();

    // Arbitration: ops win 8 times, then the user is granted.
    user_req = 1'b1;
    opcode   = 4'h1;
    op_valid = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("arb_op_wins", o_op_ready, 1);
      cyc();
      chk("arb_load_cl", cl, 5'b00010);
      cyc();
    end
    chk("arb_starved_ready", o_op_ready, 0);
    cyc();
    chk("arb_user_ack", {o_user_sample, o_user_ack, o_op_ready}, 3'b110);
    chk("arb_user_cl", cl, 5'b00000);
    user_req = 1'b0;
    op_valid = 1'b0;
    cyc();
    chk("arb_after", {o_user_ack, o_busy, o_op_ready}, 3'b001);

    // User request with no op pending wins immediately.
    user_req = 1'b1;
    #1;
    chk("user_only_ready", o_op_ready, 0);
    cyc();
    chk("user_only_ack", {o_user_sample, o_user_ack}, 2'b11);
    user_req = 1'b0;
    cyc();
    chk("user_only_idle", {o_user_ack, o_busy}, 2'b00);

    // Reset in WAIT_ALU: outputs drop at once, IDLE afterwards.
    issue(4'hA);
    cyc();
    chk("rst_mid_busy", {o_busy, C7}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", o_op_ready, 1);
    chk("rst_rel_busy_done", {o_busy, o_op_done}, 2'b00);
    cyc();
    chk("rst_rel_stay_idle", {o_busy, o_op_done}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
